// File: rtl/lcd_ctrl.sv
// rtl/lcd_ctrl.sv - HD44780-style LCD write controller with CPU toggle handshake (optional LCD_INIT_SEQ_EN power-on init)
module lcd_ctrl #(
    parameter int T_SETUP = 2,
    parameter int T_PW    = 12,
    parameter int T_HOLD  = 2,
    parameter int T_EXEC  = 2000,
    parameter int T_CLR   = 80000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] lcd_word_i,
    output logic [31:0] status_o,
    output logic [7:0]  lcd_data_o,
    output logic        lcd_rs_o,
    output logic        lcd_rw_o,
    output logic        lcd_en_o,
    output logic        lcd_on_o
);

    // Counters are loaded with (T-1) and count down to zero, so a phase lasts exactly T cycles.
    localparam logic [19:0] SETUP_LD = 20'(T_SETUP - 1);
    localparam logic [19:0] PW_LD    = 20'(T_PW - 1);
    localparam logic [19:0] HOLD_LD  = 20'(T_HOLD - 1);
    localparam logic [19:0] EXEC_LD  = 20'(T_EXEC - 1);
    localparam logic [19:0] CLR_LD   = 20'(T_CLR - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_HOLD,
        S_WAIT,
        S_INIT
    } state_t;

    state_t      state_q, state_d;
    logic [19:0] cnt_q, cnt_d;
    logic        ack_q, ack_d;
    logic        busy_q, busy_d;
    logic [7:0]  data_q, data_d;
    logic        rs_q, rs_d;
    logic        en_q, en_d;
    logic        on_q;
    logic        req_pending;
    logic        is_slow_cmd;

`ifdef LCD_INIT_SEQ_EN
    logic [1:0]  init_idx_q, init_idx_d;
    logic        init_busy_q, init_busy_d;

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    init_cmd = 8'h38;
            2'd1:    init_cmd = 8'h0C;
            2'd2:    init_cmd = 8'h01;
            default: init_cmd = 8'h06;
        endcase
    endfunction
`endif

    assign req_pending = lcd_word_i[30] != ack_q;
    // Clear and return-home commands need the long execution wait.
    assign is_slow_cmd = !rs_q && (data_q == 8'h01 || data_q == 8'h02 || data_q == 8'h03);

    assign status_o   = {30'd0, ack_q, busy_q};
    assign lcd_data_o = data_q;
    assign lcd_rs_o   = rs_q;
    assign lcd_rw_o   = 1'b0;
    assign lcd_en_o   = en_q;
    assign lcd_on_o   = on_q;

    // State, phase counter and registered output copies.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
`ifdef LCD_INIT_SEQ_EN
            state_q     <= S_INIT;
            busy_q      <= 1'b1;
            init_idx_q  <= 2'd0;
            init_busy_q <= 1'b1;
`else
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
`endif
            cnt_q  <= 20'd0;
            ack_q  <= 1'b0;
            data_q <= 8'h00;
            rs_q   <= 1'b0;
            en_q   <= 1'b0;
            on_q   <= 1'b0;
        end else begin
`ifdef LCD_INIT_SEQ_EN
            init_idx_q  <= init_idx_d;
            init_busy_q <= init_busy_d;
`endif
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            data_q  <= data_d;
            rs_q    <= rs_d;
            en_q    <= en_d;
            on_q    <= lcd_word_i[31];
        end
    end

    // Next-state logic: walk SETUP -> PULSE -> HOLD -> WAIT, then acknowledge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ack_d   = ack_q;
        data_d  = data_q;
        rs_d    = rs_q;
        en_d    = 1'b0;
`ifdef LCD_INIT_SEQ_EN
        init_idx_d  = init_idx_q;
        init_busy_d = init_busy_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req_pending) begin
                    data_d  = lcd_word_i[7:0];
                    rs_d    = lcd_word_i[9];
                    cnt_d   = SETUP_LD;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                if (cnt_q == 20'd0) begin
                    cnt_d   = PW_LD;
                    en_d    = 1'b1;
                    state_d = S_PULSE;
                end else begin
                    cnt_d = cnt_q - 20'd1;
                end
            end
            S_PULSE: begin
                if (cnt_q == 20'd0) begin
                    cnt_d   = HOLD_LD;
                    state_d = S_HOLD;
                end else begin
                    cnt_d = cnt_q - 20'd1;
                    en_d  = 1'b1;
                end
            end
            S_HOLD: begin
                if (cnt_q == 20'd0) begin
                    cnt_d   = is_slow_cmd ? CLR_LD : EXEC_LD;
                    state_d = S_WAIT;
                end else begin
                    cnt_d = cnt_q - 20'd1;
                end
            end
            S_WAIT: begin
                if (cnt_q == 20'd0) begin
`ifdef LCD_INIT_SEQ_EN
                    // Autonomous init writes never touch the CPU acknowledge.
                    if (init_busy_q) begin
                        init_idx_d = init_idx_q + 2'd1;
                        if (init_idx_q == 2'd3) begin
                            init_busy_d = 1'b0;
                            state_d     = S_IDLE;
                        end else begin
                            state_d = S_INIT;
                        end
                    end else begin
                        ack_d   = ~ack_q;
                        state_d = S_IDLE;
                    end
`else
                    ack_d   = ~ack_q;
                    state_d = S_IDLE;
`endif
                end else begin
                    cnt_d = cnt_q - 20'd1;
                end
            end
`ifdef LCD_INIT_SEQ_EN
            S_INIT: begin
                data_d  = init_cmd(init_idx_q);
                rs_d    = 1'b0;
                cnt_d   = SETUP_LD;
                state_d = S_SETUP;
            end
`endif
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE) || (lcd_word_i[30] != ack_d);
    end

endmodule

// File: tb/tb_lcd_ctrl.sv
// tb/tb_lcd_ctrl.sv - randomized self-checking bench for lcd_ctrl against a timeline reference model
module tb_lcd_ctrl;

    localparam int TS = 2;
    localparam int TP = 4;
    localparam int TH = 2;
    localparam int TE = 10;
    localparam int TC = 50;

    logic        clk;
    logic        rst;
    logic [31:0] word;
    logic [31:0] status;
    logic [7:0]  lcd_data;
    logic        lcd_rs;
    logic        lcd_rw;
    logic        lcd_en;
    logic        lcd_on;

    int n_vec  = 0;
    int n_miss = 0;

    lcd_ctrl #(
        .T_SETUP(TS),
        .T_PW   (TP),
        .T_HOLD (TH),
        .T_EXEC (TE),
        .T_CLR  (TC)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .lcd_word_i(word),
        .status_o  (status),
        .lcd_data_o(lcd_data),
        .lcd_rs_o  (lcd_rs),
        .lcd_rw_o  (lcd_rw),
        .lcd_en_o  (lcd_en),
        .lcd_on_o  (lcd_on)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: each accepted request is a timeline of total cycles,
    // with EN high for elapsed cycles in [TS, TS+TP).
    bit       m_active = 0;
    int       m_el = 0;
    int       m_total = 0;
    bit       m_ack = 0;
    bit       m_req = 0;
    bit       m_on = 0;
    bit [7:0] m_data = 0;
    bit       m_rs = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_active = 0; m_el = 0; m_ack = 0; m_req = 0; m_on = 0; m_data = 0; m_rs = 0;
        end else begin
            if (m_active) begin
                m_el++;
                if (m_el == m_total) begin
                    m_active = 0;
                    m_ack = ~m_ack;
                end
            end else if (word[30] != m_ack) begin
                m_active = 1;
                m_el = 0;
                m_data = word[7:0];
                m_rs = word[9];
                m_total = TS + TP + TH +
                          ((!word[9] && word[7:0] >= 8'h01 && word[7:0] <= 8'h03) ? TC : TE);
            end
            m_req = word[30];
            m_on = word[31];
        end
    end

    // Per-cycle comparison of every output against the model, plus pulse/busy tallies.
    int       en_rises = 0;
    int       busy_cycles = 0;
    int       en_high_cycles = 0;
    logic [7:0] last_rise_data = 8'h00;
    logic     prev_en = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            check("rst_en", {31'd0, lcd_en}, 32'd0);
            check("rst_status", status, 32'd0);
            check("rst_data", {24'd0, lcd_data}, 32'd0);
        end else begin
            check("en", {31'd0, lcd_en},
                  {31'd0, m_active && m_el >= TS && m_el < TS + TP});
            check("status", status,
                  {30'd0, m_ack, (m_active || (m_req != m_ack))});
            check("data", {24'd0, lcd_data}, {24'd0, m_data});
            check("rs", {31'd0, lcd_rs}, {31'd0, m_rs});
            check("on", {31'd0, lcd_on}, {31'd0, m_on});
            check("rw", {31'd0, lcd_rw}, 32'd0);
        end
        if (lcd_en && !prev_en) begin
            en_rises++;
            last_rise_data = lcd_data;
        end
        if (lcd_en) en_high_cycles++;
        if (status[0]) busy_cycles++;
        prev_en = lcd_en;
    end

    task automatic drive(input logic [31:0] w);
        @(negedge clk);
        #1 word = w;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_en(input int max);
        int n = 0;
        while (lcd_en !== 1'b1 && n < max) begin
            @(negedge clk);
            n++;
        end
        check("en_wait", {31'd0, lcd_en}, 32'd1);
    endtask

    int          base_rise;
    int          base_busy;
    int          base_high;
    logic [31:0] w;

    initial begin
        rst  = 1'b1;
        word = 32'd0;
        #1;
        check("reset_en", {31'd0, lcd_en}, 32'd0);
        check("reset_status", status, 32'd0);
        check("reset_data", {24'd0, lcd_data}, 32'd0);
        check("reset_rs", {31'd0, lcd_rs}, 32'd0);
        check("reset_on", {31'd0, lcd_on}, 32'd0);
        idle(3);
        #1 rst = 1'b0;
        idle(3);

        // Data write: 4-cycle EN pulse, done after 18 cycles.
        base_high = en_high_cycles;
        drive(32'h4000_0241);
        idle(25);
        check("data_wr_en_width", en_high_cycles - base_high, 4);
        check("data_wr_status", status, 32'h2);

        // Clear command: 58 busy cycles.
        base_busy = busy_cycles;
        drive(32'h0000_0001);
        idle(70);
        check("clr_busy_cycles", busy_cycles - base_busy, 58);
        check("clr_status", status, 32'h0);

        // Second toggle mid-pulse queues exactly one more write.
        base_rise = en_rises;
        drive(32'h4000_0241);
        wait_en(10);
        drive(32'h0000_0242);
        idle(60);
        check("queued_pulses", en_rises - base_rise, 2);
        check("queued_last_data", {24'd0, last_rise_data}, 32'h42);

        // Two toggles while busy cancel out.
        base_rise = en_rises;
        drive(32'h4000_0243);
        idle(3);
        drive(32'h0000_0243);
        idle(2);
        drive(32'h4000_0243);
        idle(40);
        check("cancel_pulses", en_rises - base_rise, 1);

        // Random traffic: data bits churn every cycle, occasional toggles and clear-class commands.
        w = word;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            #1;
            w[7:0] = 8'($urandom);
            w[9]   = 1'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                w[9]   = 1'b0;
                w[7:0] = 8'($urandom_range(1, 3));
            end
            if ($urandom_range(0, 29) == 0) w[30] = ~w[30];
            if ($urandom_range(0, 49) == 0) w[31] = ~w[31];
            word = w;
        end
        idle(80);

        // Reset mid-pulse drops EN at once and abandons the transfer.
        drive({word[31], ~status[1], word[29:10], 1'b1, word[8], 8'h5A});
        wait_en(100);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_en", {31'd0, lcd_en}, 32'd0);
        check("midrst_status", status, 32'd0);
        check("midrst_data", {24'd0, lcd_data}, 32'd0);
        word = 32'd0;
        idle(2);
        #1 rst = 1'b0;
        idle(3);

        // Recovery after reset.
        base_rise = en_rises;
        drive(32'h4000_0244);
        idle(25);
        check("recover_pulses", en_rises - base_rise, 1);
        check("recover_status", status, 32'h2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/lcd_ctrl.md
LCD_CTRL -- requirements
Module: lcd_ctrl

Interface
REQ-001 SHALL have parameter T_SETUP, default 2, meaning RS/DATA setup cycles before EN rises (range 1..2^20-1).
REQ-002 SHALL have parameter T_PW, default 12, meaning EN high cycles (range 1..2^20-1).
REQ-003 SHALL have parameter T_HOLD, default 2, meaning cycles after EN falls with DATA held (range 1..2^20-1).
REQ-004 SHALL have parameter T_EXEC, default 2000, meaning wait cycles for a normal command or data write (range 1..2^20-1).
REQ-005 SHALL have parameter T_CLR, default 80000, meaning wait cycles for clear or home commands (range 1..2^20-1).
REQ-006 SHALL use one clock and an asynchronous, active-high reset.
REQ-007 clk_i  input  1  rising-edge clock.
REQ-008 rst_i  input  1  asynchronous active-high reset.
REQ-009 lcd_word_i  input  32  CPU LCD register: [31] ON, [30] REQ toggle, [9] RS, [7:0] DATA; other bits ignored.
REQ-010 status_o  output  32  CPU readback: [0] busy, [1] ACK toggle, others 0.
REQ-011 lcd_data_o  output  8  LCD data bus.
REQ-012 lcd_rs_o  output  1  LCD register select.
REQ-013 lcd_rw_o  output  1  LCD read/write; constant 0 (write-only).
REQ-014 lcd_en_o  output  1  LCD enable strobe.
REQ-015 lcd_on_o  output  1  LCD power; registered copy of lcd_word_i[31].

Function
REQ-016 SHALL implement FSM states IDLE, SETUP, PULSE, HOLD, WAIT; all outputs registered.
REQ-017 A request is pending when lcd_word_i[30] != ack; in IDLE with a request pending, the block SHALL latch RS/DATA and enter SETUP on the same edge.
REQ-018 SETUP SHALL last T_SETUP cycles, PULSE T_PW cycles (lcd_en_o=1 only here), HOLD T_HOLD cycles, and WAIT T_EXEC or T_CLR cycles; then ack flips and the FSM returns to IDLE.
REQ-019 WAIT SHALL use T_CLR when RS=0 and DATA is 0x01, 0x02 or 0x03; otherwise it SHALL use T_EXEC.
REQ-020 lcd_data_o and lcd_rs_o SHALL stay stable from SETUP entry through HOLD exit.
REQ-021 The latency from acceptance to the ack flip SHALL be exactly T_SETUP+T_PW+T_HOLD+wait cycles.
REQ-022 status_o[0] SHALL be 1 in any state other than IDLE, and also while a request is pending.
REQ-023 REQ toggles while busy SHALL leave at most one request pending; an even number of toggles during busy SHALL cancel to none (documented, not an error).
REQ-024 A request SHALL be accepted in the IDLE cycle immediately after the ack flip, giving back-to-back operation with no dead cycle beyond that.
REQ-025 Phase counters SHALL be 20-bit and count down from (T-1) to 0, with no wrap.
REQ-026 lcd_on_o SHALL update every cycle regardless of FSM state.

Reset
REQ-027 On reset: FSM=IDLE (or INIT when configured), ack=0, lcd_en_o=0, lcd_rs_o=0, lcd_data_o=0x00, lcd_rw_o=0, lcd_on_o=0, counters=0.
REQ-028 Reset asserted mid-operation SHALL force lcd_en_o=0 immediately (asynchronously), abandon the transfer, and leave ack at 0.

Configuration
REQ-029 Macro LCD_INIT_SEQ_EN, when defined: after reset the FSM SHALL autonomously send commands 0x38, 0x0C, 0x01, 0x06 (RS=0) using the normal timing, holding status_o[0]=1 and not accepting CPU requests until done; ack SHALL remain unchanged.
REQ-030 Without LCD_INIT_SEQ_EN, the FSM SHALL enter IDLE directly after reset and no autonomous writes SHALL occur.

Verification (T_SETUP=2, T_PW=4, T_HOLD=2, T_EXEC=10, T_CLR=50; macro undefined unless stated)
REQ-031 Write lcd_word_i=0x4000_0241 (REQ=1, RS=1, DATA=0x41) -> lcd_rs_o=1, lcd_data_o=0x41, lcd_en_o high exactly 4 cycles starting 2 cycles after acceptance; status_o=0x2 after 18 cycles.
REQ-032 Write RS=0, DATA=0x01 -> busy for 58 cycles, then status_o[1] flips.
REQ-033 Toggle REQ with DATA=0x41, then toggle again with DATA=0x42 mid-PULSE -> 0x41 completes and is followed by exactly one 0x42 write, i.e. two EN pulses.
REQ-034 Toggle REQ twice while busy -> exactly one EN pulse total (the original).
REQ-035 Assert rst_i during PULSE -> lcd_en_o=0 within the same cycle, status_o=0, lcd_data_o=0x00.
REQ-036 With LCD_INIT_SEQ_EN defined -> after reset, EN pulses carry 0x38, 0x0C, 0x01, 0x06 with waits 10/10/50/10, and a CPU request made during this sequence is served after it.
